pipeline_stall_ctrl: RTL and testbench

Central pipeline controller for the 5-stage RV32 core. It consumes the load-use stall request from the hazard detection unit, the branch-taken resolution from EX, and the data-memory handshake from MEM. From these it produces the per-stage write enables, bubbles and flushes. It also tracks multi-cycle memory waits with a timeout and keeps saturating performance counters for stalls, freezes and flushes.

---
 rtl/pipeline_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage RV32 pipeline.
// Resolves load-use stalls, branch flushes and memory freezes, with a wait timeout and saturating perf counters.
module pipeline_stall_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load_use_stall,
   input  logic             i_branch_taken,
   input  logic             i_dmem_req,
   input  logic             i_dmem_ready,
   output logic             o_pc_write,
   output logic             o_ifid_write,
   output logic             o_ifid_flush,
   output logic             o_idex_bubble,
   output logic             o_exmem_write,
   output logic             o_memwb_bubble,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_freeze_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  freeze_cnt_q, freeze_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              freeze_c;

   // A request completing in the same cycle is zero-wait and never freezes.
   assign freeze_c = i_dmem_req & ~i_dmem_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_BOOT;
         wait_q       <= '0;
         stall_cnt_q  <= '0;
         freeze_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         stall_cnt_q  <= stall_cnt_d;
         freeze_cnt_q <= freeze_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      stall_cnt_d    = stall_cnt_q;
      freeze_cnt_d   = freeze_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      o_pc_write     = 1'b0;
      o_ifid_write   = 1'b0;
      o_ifid_flush   = 1'b0;
      o_idex_bubble  = 1'b0;
      o_exmem_write  = 1'b0;
      o_memwb_bubble = 1'b1;

      unique case (state_q)
         ST_BOOT: begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            wait_d        = '0;
            state_d       = ST_RUN;
         end

         ST_RUN: begin
            if (freeze_c) begin
               // Everything upstream of MEM holds; a taken branch in EX is re-presented later.
               if (freeze_cnt_q != CNT_MAX) begin
                  freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
               end
               if (wait_q == WAIT_LAST) begin
                  state_d = ST_ERROR;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end else begin
               wait_d         = '0;
               o_memwb_bubble = 1'b0;
               o_exmem_write  = 1'b1;
               if (i_branch_taken) begin
                  o_pc_write    = 1'b1;
                  o_ifid_write  = 1'b1;
                  o_ifid_flush  = 1'b1;
                  o_idex_bubble = 1'b1;
                  if (flush_cnt_q != CNT_MAX) begin
                     flush_cnt_d = flush_cnt_q + CNT_W'(1);
                  end
               end else if (i_load_use_stall) begin
                  o_idex_bubble = 1'b1;
                  if (stall_cnt_q != CNT_MAX) begin
                     stall_cnt_d = stall_cnt_q + CNT_W'(1);
                  end
               end else begin
                  o_pc_write   = 1'b1;
                  o_ifid_write = 1'b1;
               end
            end
         end

         ST_ERROR: begin
            state_d = ST_ERROR;
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign o_mem_timeout = (state_q == ST_ERROR);
   assign o_stall_cnt   = stall_cnt_q;
   assign o_freeze_cnt  = freeze_cnt_q;
   assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (TIMEOUT_CYCLES=4, CNT_W=3).
module tb_pipeline_stall_ctrl;

   logic       clk;
   logic       rst;
   logic       load_use;
   logic       branch;
   logic       dreq;
   logic       dready;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble, mem_timeout;
   logic [2:0] stall_cnt, freeze_cnt, flush_cnt;
   logic [6:0] outs;

   int checks = 0;
   int errors = 0;

   // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble, mem_timeout}
   localparam logic [6:0] O_BOOT   = 7'b0011010;
   localparam logic [6:0] O_IDLE   = 7'b1100100;
   localparam logic [6:0] O_STALL  = 7'b0001100;
   localparam logic [6:0] O_FLUSH  = 7'b1111100;
   localparam logic [6:0] O_FREEZE = 7'b0000010;
   localparam logic [6:0] O_ERROR  = 7'b0000011;

   pipeline_stall_ctrl #(
      .TIMEOUT_CYCLES(4),
      .CNT_W         (3)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_load_use_stall(load_use),
      .i_branch_taken  (branch),
      .i_dmem_req      (dreq),
      .i_dmem_ready    (dready),
      .o_pc_write      (pc_write),
      .o_ifid_write    (ifid_write),
      .o_ifid_flush    (ifid_flush),
      .o_idex_bubble   (idex_bubble),
      .o_exmem_write   (exmem_write),
      .o_memwb_bubble  (memwb_bubble),
      .o_mem_timeout   (mem_timeout),
      .o_stall_cnt     (stall_cnt),
      .o_freeze_cnt    (freeze_cnt),
      .o_flush_cnt     (flush_cnt)
   );

   assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble, mem_timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic lu, input logic br, input logic rq, input logic rd);
      load_use = lu;
      branch   = br;
      dreq     = rq;
      dready   = rd;
   endtask

   // Leaves the DUT in RUN, one time unit past a falling edge, inputs idle.
   task automatic do_reset();
      set_in(0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (outs !== O_BOOT || {stall_cnt, freeze_cnt, flush_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL reset_hold outs=%b cnts=%h exp outs=%b cnts=0", outs, {stall_cnt, freeze_cnt, flush_cnt}, O_BOOT);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (outs !== O_BOOT) begin
         errors++;
         $display("FAIL boot_cycle outs=%b exp %b", outs, O_BOOT);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs !== O_IDLE || {stall_cnt, freeze_cnt, flush_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL run_idle outs=%b cnts=%h exp outs=%b cnts=0", outs, {stall_cnt, freeze_cnt, flush_cnt}, O_IDLE);
      end
   endtask

   task automatic test_stall();
      do_reset();
      set_in(1, 0, 0, 0);
      #1;
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL stall_outs outs=%b exp %b", outs, O_STALL);
      end
      @(negedge clk);
      set_in(0, 0, 0, 1);
      #1;
      checks++;
      if (outs !== O_IDLE || stall_cnt !== 3'd1 || flush_cnt !== 3'd0 || freeze_cnt !== 3'd0) begin
         errors++;
         $display("FAIL stall_count outs=%b stall=%0d flush=%0d freeze=%0d exp outs=%b 1 0 0",
                  outs, stall_cnt, flush_cnt, freeze_cnt, O_IDLE);
      end
   endtask

   task automatic test_branch_over_stall();
      do_reset();
      set_in(1, 1, 0, 0);
      #1;
      checks++;
      if (outs !== O_FLUSH) begin
         errors++;
         $display("FAIL branch_stall_outs outs=%b exp %b", outs, O_FLUSH);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0);
      #1;
      checks++;
      if (flush_cnt !== 3'd1 || stall_cnt !== 3'd0) begin
         errors++;
         $display("FAIL branch_stall_cnt flush=%0d stall=%0d exp 1 0", flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_freeze_branch();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1, 1, 0);
         #1;
         checks++;
         if (outs !== O_FREEZE) begin
            errors++;
            $display("FAIL freeze_cycle%0d outs=%b exp %b", i, outs, O_FREEZE);
         end
         @(negedge clk);
      end
      set_in(0, 1, 1, 1);
      #1;
      checks++;
      if (outs !== O_FLUSH || freeze_cnt !== 3'd3 || flush_cnt !== 3'd0) begin
         errors++;
         $display("FAIL freeze_release outs=%b freeze=%0d flush=%0d exp %b 3 0", outs, freeze_cnt, flush_cnt, O_FLUSH);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0);
      #1;
      checks++;
      if (outs !== O_IDLE || freeze_cnt !== 3'd3 || flush_cnt !== 3'd1) begin
         errors++;
         $display("FAIL freeze_after outs=%b freeze=%0d flush=%0d exp %b 3 1", outs, freeze_cnt, flush_cnt, O_IDLE);
      end
   endtask

   task automatic test_wait_clear();
      // 2 freezes, a gap, then 3 freezes: the gap must restart the wait count.
      do_reset();
      set_in(0, 0, 1, 0);
      repeat (2) @(negedge clk);
      set_in(0, 0, 0, 1);
      @(negedge clk);
      set_in(0, 0, 1, 0);
      repeat (3) @(negedge clk);
      set_in(0, 0, 1, 1);
      #1;
      checks++;
      if (outs !== O_IDLE || freeze_cnt !== 3'd5) begin
         errors++;
         $display("FAIL wait_clear outs=%b freeze=%0d exp %b 5", outs, freeze_cnt, O_IDLE);
      end
      @(negedge clk);
      #1;
      checks++;
      if (mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL wait_clear_to timeout=%b exp 0", mem_timeout);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 1, 0);
         #1;
         checks++;
         if (outs !== O_FREEZE) begin
            errors++;
            $display("FAIL to_freeze%0d outs=%b exp %b", i, outs, O_FREEZE);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (outs !== O_ERROR || freeze_cnt !== 3'd4) begin
         errors++;
         $display("FAIL to_enter outs=%b freeze=%0d exp %b 4", outs, freeze_cnt, O_ERROR);
      end
      set_in(1, 1, 1, 1);
      repeat (2) @(negedge clk);
      set_in(0, 1, 0, 0);
      #1;
      checks++;
      if (outs !== O_ERROR || freeze_cnt !== 3'd4 || stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin
         errors++;
         $display("FAIL to_sticky outs=%b freeze=%0d stall=%0d flush=%0d exp %b 4 0 0",
                  outs, freeze_cnt, stall_cnt, flush_cnt, O_ERROR);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== O_BOOT || {stall_cnt, freeze_cnt, flush_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL to_async_clear outs=%b cnts=%h exp %b 0", outs, {stall_cnt, freeze_cnt, flush_cnt}, O_BOOT);
      end
   endtask

   task automatic test_saturation();
      int exp_cnt;
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         set_in(1, 0, 0, 0);
         @(negedge clk);
         #1;
         exp_cnt = (i > 7) ? 7 : i;
         checks++;
         if (stall_cnt !== 3'(exp_cnt)) begin
            errors++;
            $display("FAIL sat_stall%0d stall=%0d exp %0d", i, stall_cnt, exp_cnt);
         end
      end
      set_in(0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0);
      test_reset();
      test_stall();
      test_branch_over_stall();
      test_freeze_branch();
      test_wait_clear();
      test_timeout();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
